// File: rtl/noc_sa_pkg.sv
// noc_sa_pkg: shared constants and helpers for the N-port switch allocator.
//   - MAX_PORTS       : largest supported router radix
//   - PORT_*          : conventional port indices of a 2D-mesh router
//   - lock_state_e    : per-output wormhole lock state
//   - dst_is_empty()  : true when a destination field encodes "no request"
//   - cyclic_next()   : next index in a ring of n entries (wraps n-1 -> 0)
package noc_sa_pkg;

    localparam int MAX_PORTS = 16;

    // Mesh direction indices as used by the route-compute stage.
    localparam int PORT_LOCAL = 0;
    localparam int PORT_XPOS  = 1;
    localparam int PORT_XNEG  = 2;
    localparam int PORT_YPOS  = 3;
    localparam int PORT_YNEG  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // Any destination index at or beyond the port count means "empty".
    function automatic bit dst_is_empty(input int dst, input int n);
        return dst >= n;
    endfunction

    function automatic int cyclic_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req : request vector, one bit per input
//   ptr : highest-priority index; search proceeds cyclically from here
//   gnt : one-hot grant (all zero when no request)
//   idx : binary index of the granted input (0 when no request)
//   any : at least one request present
module rr_arbiter
    import noc_sa_pkg::*;
#(
    parameter  int NUM_PORTS = 5,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PORT_W-1:0]    idx,
    output logic                 any
);

    logic [PORT_W:0]   sum;
    logic [PORT_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // ptr + k folded back into 0..NUM_PORTS-1 (ptr is always < NUM_PORTS)
            sum = {1'b0, ptr} + (PORT_W+1)'(k);
            if (sum >= (PORT_W+1)'(NUM_PORTS)) begin
                sum = sum - (PORT_W+1)'(NUM_PORTS);
            end
            cand = sum[PORT_W-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/switch_allocator_np.sv
// switch_allocator_np: N-port switch allocator with per-output round-robin
// arbitration and wormhole packet locking.
//   clk, rst_n : router clock, asynchronous active-low reset
//   en         : allocator enable; low freezes all state and suppresses grants
//   in_req     : input i has a flit requesting switch traversal
//   in_dst     : requested output index per input (slice i); >= NUM_PORTS is empty
//   in_tail    : input i's flit ends its packet
//   out_busy   : output o has no downstream credit
//   in_gnt     : registered; input i's flit traverses (pop its buffer)
//   out_sw     : registered crossbar select per output (slice o)
//   out_vld    : registered; output o carries a valid flit
module switch_allocator_np
    import noc_sa_pkg::*;
#(
    parameter  int NUM_PORTS = 5,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_PORTS-1:0]        in_req,
    input  logic [NUM_PORTS*PORT_W-1:0] in_dst,
    input  logic [NUM_PORTS-1:0]        in_tail,
    input  logic [NUM_PORTS-1:0]        out_busy,
    output logic [NUM_PORTS-1:0]        in_gnt,
    output logic [NUM_PORTS*PORT_W-1:0] out_sw,
    output logic [NUM_PORTS-1:0]        out_vld
);

    // grant_mat[o][i]: output o grants input i this cycle
    logic [NUM_PORTS-1:0] grant_mat [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_gnt_next;
    logic [NUM_PORTS-1:0] in_gnt_reg;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
        logic [NUM_PORTS-1:0] req_vec;
        logic [NUM_PORTS-1:0] arb_gnt;
        logic [PORT_W-1:0]    arb_idx;
        logic                 arb_any;
        logic                 locked;
        logic                 fire;
        logic [PORT_W-1:0]    win;

        lock_state_e          state_reg;
        logic [PORT_W-1:0]    owner_reg;
        logic [PORT_W-1:0]    ptr_reg;
        logic [PORT_W-1:0]    sw_reg;
        logic                 vld_reg;

        for (genvar gj = 0; gj < NUM_PORTS; gj++) begin : g_req
            assign req_vec[gj] = in_req[gj]
                && !dst_is_empty(int'(in_dst[gj*PORT_W +: PORT_W]), NUM_PORTS)
                && (in_dst[gj*PORT_W +: PORT_W] == PORT_W'(gi));
        end

        rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .req (req_vec),
            .ptr (ptr_reg),
            .gnt (arb_gnt),
            .idx (arb_idx),
            .any (arb_any)
        );

        // While locked only the owner may use the output; everyone else waits.
        always_comb begin
            locked = (state_reg == ST_LOCKED);
            win    = locked ? owner_reg : arb_idx;
            fire   = en && !out_busy[gi] && (locked ? req_vec[owner_reg] : arb_any);
        end

        assign grant_mat[gi] = !fire  ? '0 :
                               locked ? (NUM_PORTS'(1) << owner_reg) : arb_gnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= ST_IDLE;
                owner_reg <= '0;
                ptr_reg   <= '0;
                sw_reg    <= '0;
                vld_reg   <= 1'b0;
            end else begin
                vld_reg <= fire;
                if (fire) begin
                    sw_reg <= win;
                    if (in_tail[win]) begin
                        // Packet finished: release and rotate priority past the winner.
                        state_reg <= ST_IDLE;
                        ptr_reg   <= PORT_W'(cyclic_next(int'(win), NUM_PORTS));
                    end else begin
                        state_reg <= ST_LOCKED;
                        owner_reg <= win;
                    end
                end
            end
        end

        assign out_sw[gi*PORT_W +: PORT_W] = sw_reg;
        assign out_vld[gi]                 = vld_reg;
    end

    // Each input names a single destination, so at most one row hits per input.
    always_comb begin
        in_gnt_next = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            in_gnt_next = in_gnt_next | grant_mat[o];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_gnt_reg <= '0;
        end else begin
            in_gnt_reg <= in_gnt_next;
        end
    end

    assign in_gnt = in_gnt_reg;

endmodule

// File: tb/tb_switch_allocator_np.sv
// tb_switch_allocator_np: directed self-checking bench for switch_allocator_np
// with NUM_PORTS=5. Inputs change 1 time unit after a rising edge; outputs are
// checked 1 time unit after the edge that registers them.
module tb_switch_allocator_np;

    localparam int N = 5;
    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en;
    logic [N-1:0]   in_req;
    logic [N*W-1:0] in_dst;
    logic [N-1:0]   in_tail;
    logic [N-1:0]   out_busy;
    logic [N-1:0]   in_gnt;
    logic [N*W-1:0] out_sw;
    logic [N-1:0]   out_vld;

    int n_checks = 0;
    int n_fail   = 0;

    switch_allocator_np #(.NUM_PORTS(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_req   (in_req),
        .in_dst   (in_dst),
        .in_tail  (in_tail),
        .out_busy (out_busy),
        .in_gnt   (in_gnt),
        .out_sw   (out_sw),
        .out_vld  (out_vld)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sw_of(input int o);
        return out_sw[o*W +: W];
    endfunction

    task automatic req_on(input int i, input int dst, input logic tail);
        in_req[i]         = 1'b1;
        in_dst[i*W +: W]  = W'(dst);
        in_tail[i]        = tail;
    endtask

    task automatic req_off(input int i);
        in_req[i]         = 1'b0;
        in_tail[i]        = 1'b0;
        in_dst[i*W +: W]  = 3'd7;
    endtask

    task automatic idle_all();
        in_req   = '0;
        in_tail  = '0;
        in_dst   = '1;
        out_busy = '0;
        en       = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: advance, log, and check vld/gnt (and out_sw[o] when o >= 0).
    task automatic expect_cyc(input string tag, input logic [N-1:0] vld,
                              input logic [N-1:0] gnt, input int o, input int sw);
        tick();
        $display("%s: vld=%b gnt=%b sw=%h", tag, out_vld, in_gnt, out_sw);
        check_eq({tag, "_vld"}, 32'(out_vld), 32'(vld));
        check_eq({tag, "_gnt"}, 32'(in_gnt), 32'(gnt));
        if (o >= 0) check_eq({tag, "_sw"}, 32'(sw_of(o)), 32'(sw));
    endtask

    initial begin
        int rr_seq [6] = '{0, 2, 4, 0, 2, 4};

        idle_all();
        // Reset state, asserted from time zero.
        #3;
        check_eq("rst_vld", 32'(out_vld), 32'd0);
        check_eq("rst_gnt", 32'(in_gnt), 32'd0);
        check_eq("rst_sw", 32'(out_sw), 32'd0);
        #19 rst_n = 1'b1;

        // Idle after reset: nothing requested, nothing granted.
        for (int c = 0; c < 10; c++) begin
            expect_cyc("idle", 5'b00000, 5'b00000, -1, 0);
            check_eq("idle_sw", 32'(out_sw), 32'd0);
        end

        // Round-robin on output 1 among inputs 0, 2, 4 (single-flit packets).
        req_on(0, 1, 1'b1);
        req_on(2, 1, 1'b1);
        req_on(4, 1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            expect_cyc("rr", 5'b00010, N'(1 << rr_seq[k]), 1, rr_seq[k]);
        end
        idle_all();
        expect_cyc("rr_hold", 5'b00000, 5'b00000, 1, 4);

        // Wormhole lock on output 0: input 3 owns it head..tail, input 1 waits.
        req_on(3, 0, 1'b0);
        expect_cyc("wh_head", 5'b00001, 5'b01000, 0, 3);
        req_on(1, 0, 1'b1);
        expect_cyc("wh_body", 5'b00001, 5'b01000, 0, 3);
        expect_cyc("wh_body", 5'b00001, 5'b01000, 0, 3);
        in_tail[3] = 1'b1;
        expect_cyc("wh_tail", 5'b00001, 5'b01000, 0, 3);
        req_off(3);
        expect_cyc("wh_next", 5'b00001, 5'b00010, 0, 1);
        req_off(1);
        expect_cyc("wh_idle", 5'b00000, 5'b00000, 0, 1);

        // Backpressure on output 2 while locked to input 4.
        req_on(4, 2, 1'b0);
        expect_cyc("bp_head", 5'b00100, 5'b10000, 2, 4);
        out_busy[2] = 1'b1;
        req_on(0, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            expect_cyc("bp_busy", 5'b00000, 5'b00000, 2, 4);
        end
        out_busy[2] = 1'b0;
        in_tail[4]  = 1'b1;
        expect_cyc("bp_resume", 5'b00100, 5'b10000, 2, 4);
        req_off(4);
        expect_cyc("bp_next", 5'b00100, 5'b00001, 2, 0);
        req_off(0);
        expect_cyc("bp_idle", 5'b00000, 5'b00000, 2, 0);

        // Enable freeze on output 3: pointer moves to 3 first, then holds.
        req_on(2, 3, 1'b1);
        expect_cyc("en_pre", 5'b01000, 5'b00100, 3, 2);
        req_off(2);
        req_on(1, 3, 1'b1);
        req_on(4, 3, 1'b1);
        en = 1'b0;
        expect_cyc("en_off", 5'b00000, 5'b00000, 3, 2);
        expect_cyc("en_off", 5'b00000, 5'b00000, 3, 2);
        en = 1'b1;
        expect_cyc("en_on", 5'b01000, 5'b10000, 3, 4);
        req_off(4);
        expect_cyc("en_next", 5'b01000, 5'b00010, 3, 1);
        idle_all();
        expect_cyc("en_idle", 5'b00000, 5'b00000, 3, 1);

        // Empty destination encodings are never granted.
        for (int d = 5; d < 8; d++) begin
            req_on(0, d, 1'b1);
            expect_cyc("bad_dst", 5'b00000, 5'b00000, -1, 0);
        end
        idle_all();

        // Pointer wrap on output 4: ptr 4, requesters 0 and 3 -> 0 wins.
        req_on(3, 4, 1'b1);
        expect_cyc("wrap_pre", 5'b10000, 5'b01000, 4, 3);
        req_on(0, 4, 1'b1);
        expect_cyc("wrap", 5'b10000, 5'b00001, 4, 0);
        expect_cyc("wrap2", 5'b10000, 5'b01000, 4, 3);
        idle_all();
        expect_cyc("wrap_idle", 5'b00000, 5'b00000, 4, 3);

        // Reset mid-packet: outputs clear at once and the lock is gone.
        req_on(2, 0, 1'b0);
        expect_cyc("mp_head", 5'b00001, 5'b00100, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mp_rst_vld", 32'(out_vld), 32'd0);
        check_eq("mp_rst_gnt", 32'(in_gnt), 32'd0);
        check_eq("mp_rst_sw", 32'(out_sw), 32'd0);
        #2 rst_n = 1'b1;
        req_off(2);
        req_on(1, 0, 1'b1);
        expect_cyc("mp_after", 5'b00001, 5'b00010, 0, 1);
        idle_all();
        expect_cyc("mp_idle", 5'b00000, 5'b00000, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
